// File: rtl/crop_norm_pkg.sv
// Shared types, widths and the saturation helper for the crop/normalize block.
package crop_norm_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  localparam int unsigned DIFF_W = 9;
  localparam int unsigned PROD_W = 25;

  // Clamp a signed product into the signed range of an out_w-bit result.
  function automatic logic signed [PROD_W-1:0] sat_s(input logic signed [PROD_W-1:0] prod,
                                                     input int unsigned out_w);
    logic signed [PROD_W-1:0] hi;
    logic signed [PROD_W-1:0] lo;
    hi = PROD_W'((longint'(1) <<< (out_w - 1)) - longint'(1));
    lo = ~hi;
    if (prod > hi) begin
      return hi;
    end else if (prod < lo) begin
      return lo;
    end
    return prod;
  endfunction

endpackage

// File: rtl/crop_norm_datapath.sv
// Two-stage subtract / multiply-shift-saturate pipeline; every stage moves only on advance.
module crop_norm_datapath
  import crop_norm_pkg::*;
#(
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned NORM_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    advance,
  input  logic                    in_valid,
  input  logic [7:0]              in_pix,
  input  logic                    in_last,
  input  logic [7:0]              offset,
  input  logic signed [15:0]      scale,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy
);

  logic                     st1_valid;
  logic                     st1_last;
  logic signed [DIFF_W-1:0] st1_diff;

  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [PROD_W-1:0] sat;

  always_comb begin
    diff    = $signed({1'b0, in_pix}) - $signed({1'b0, offset});
    prod    = PROD_W'(st1_diff) * PROD_W'(scale);
    shifted = prod >>> NORM_SHIFT;
    sat     = sat_s(shifted, OUT_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st1_valid <= 1'b0;
      st1_last  <= 1'b0;
      st1_diff  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (advance) begin
      st1_valid <= in_valid;
      if (in_valid) begin
        st1_diff <= diff;
        st1_last <= in_last;
      end
      out_valid <= st1_valid;
      out_last  <= st1_valid & st1_last;
      if (st1_valid) begin
        out_data <= OUT_W'(sat);
      end
    end
  end

  assign busy = st1_valid | out_valid;

endmodule

// File: rtl/crop_norm_mono8.sv
// Crops a tagged Mono8 stream to a fixed window and normalizes it to signed fixed point.
// Optional pixel statistics outputs are enabled with the CROP_NORM_STATS_EN macro.
module crop_norm_mono8
  import crop_norm_pkg::*;
#(
  parameter int unsigned IN_ROWS    = 20,
  parameter int unsigned IN_COLS    = 20,
  parameter int unsigned CROP_ROW0  = 0,
  parameter int unsigned CROP_COL0  = 0,
  parameter int unsigned CROP_ROWS  = 16,
  parameter int unsigned CROP_COLS  = 16,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned NORM_SHIFT = 8,
  localparam int unsigned CW        = $clog2(IN_COLS),
  localparam int unsigned RW        = $clog2(IN_ROWS),
  localparam int unsigned SUM_W     = $clog2(CROP_ROWS * CROP_COLS * 255 + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_ready,
  output logic                    ap_idle,
  input  logic [7:0]              norm_offset,
  input  logic signed [15:0]      norm_scale,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [7:0]              s_axis_tdata,
  input  logic [CW-1:0]           in_col,
  input  logic [RW-1:0]           in_row,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [OUT_W-1:0]        m_axis_tdata,
  output logic                    m_axis_tlast
`ifdef CROP_NORM_STATS_EN
  ,
  output logic [7:0]              stat_min,
  output logic [7:0]              stat_max,
  output logic [SUM_W-1:0]        stat_sum
`endif
);

  state_e             state;
  logic [7:0]         offset_q;
  logic signed [15:0] scale_q;

  logic advance;
  logic accept;
  logic keep;
  logic frame_end;
  logic crop_last;
  logic pipe_busy;

  always_comb begin
    advance       = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = (state == StRun) && advance;
    accept        = s_axis_tvalid && s_axis_tready;
    keep          = (32'(in_row) >= CROP_ROW0) && (32'(in_row) < CROP_ROW0 + CROP_ROWS) &&
                    (32'(in_col) >= CROP_COL0) && (32'(in_col) < CROP_COL0 + CROP_COLS);
    frame_end     = (32'(in_row) == IN_ROWS - 1) && (32'(in_col) == IN_COLS - 1);
    crop_last     = (32'(in_row) == CROP_ROW0 + CROP_ROWS - 1) &&
                    (32'(in_col) == CROP_COL0 + CROP_COLS - 1);
  end

  crop_norm_datapath #(
    .OUT_W      (OUT_W),
    .NORM_SHIFT (NORM_SHIFT)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .in_valid  (accept && keep),
    .in_pix    (s_axis_tdata),
    .in_last   (crop_last),
    .offset    (offset_q),
    .scale     (scale_q),
    .out_valid (m_axis_tvalid),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .busy      (pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      ap_done  <= 1'b0;
      ap_ready <= 1'b1;
      ap_idle  <= 1'b1;
      offset_q <= '0;
      scale_q  <= '0;
    end else begin
      ap_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (ap_start) begin
            offset_q <= norm_offset;
            scale_q  <= norm_scale;
            state    <= StRun;
            ap_idle  <= 1'b0;
            ap_ready <= 1'b0;
          end
        end
        StRun: begin
          if (accept && frame_end) begin
            state <= StFlush;
          end
        end
        StFlush: begin
          // Input is closed here; wait for both pipeline stages to drain.
          if (!pipe_busy) begin
            state   <= StDone;
            ap_done <= 1'b1;
          end
        end
        StDone: begin
          state    <= StIdle;
          ap_idle  <= 1'b1;
          ap_ready <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef CROP_NORM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || (state == StIdle && ap_start)) begin
      stat_min <= 8'hFF;
      stat_max <= 8'h00;
      stat_sum <= '0;
    end else if (accept && keep) begin
      if (s_axis_tdata < stat_min) stat_min <= s_axis_tdata;
      if (s_axis_tdata > stat_max) stat_max <= s_axis_tdata;
      stat_sum <= stat_sum + SUM_W'(s_axis_tdata);
    end
  end
`endif

endmodule

// File: tb/tb_crop_norm_mono8.sv
// Directed, table-driven bench: 4x4 frames cropped to the 2x2 window at (1,1), two shift settings.
module tb_crop_norm_mono8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic [7:0]  norm_offset = '0;
  logic [15:0] norm_scale = '0;
  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic [1:0]  in_col = '0;
  logic [1:0]  in_row = '0;
  logic        m_axis_tready = 1'b1;

  logic        ap_done, ap_ready, ap_idle, s_axis_tready;
  logic        m8_tvalid, m8_tlast;
  logic [15:0] m8_tdata;
  logic        d0_done, d0_ready, d0_idle, d0_sready;
  logic        m0_tvalid, m0_tlast;
  logic [15:0] m0_tdata;
`ifdef CROP_NORM_STATS_EN
  logic [7:0]  stat_min, stat_max, s0_min, s0_max;
  logic [9:0]  stat_sum, s0_sum;
`endif

  always #5 clk = ~clk;

  crop_norm_mono8 #(
    .IN_ROWS(4), .IN_COLS(4), .CROP_ROW0(1), .CROP_COL0(1), .CROP_ROWS(2), .CROP_COLS(2),
    .OUT_W(16), .NORM_SHIFT(8)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .norm_offset(norm_offset), .norm_scale(norm_scale),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .in_col(in_col), .in_row(in_row), .m_axis_tvalid(m8_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m8_tdata), .m_axis_tlast(m8_tlast)
`ifdef CROP_NORM_STATS_EN
    , .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum)
`endif
  );

  crop_norm_mono8 #(
    .IN_ROWS(4), .IN_COLS(4), .CROP_ROW0(1), .CROP_COL0(1), .CROP_ROWS(2), .CROP_COLS(2),
    .OUT_W(16), .NORM_SHIFT(0)
  ) dut0 (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_done(d0_done), .ap_ready(d0_ready),
    .ap_idle(d0_idle), .norm_offset(norm_offset), .norm_scale(norm_scale),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(d0_sready), .s_axis_tdata(s_axis_tdata),
    .in_col(in_col), .in_row(in_row), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m0_tdata), .m_axis_tlast(m0_tlast)
`ifdef CROP_NORM_STATS_EN
    , .stat_min(s0_min), .stat_max(s0_max), .stat_sum(s0_sum)
`endif
  );

  typedef struct packed {
    logic [7:0]        off;
    logic [15:0]       scale;
    bit                ramp;
    logic [7:0]        pix;
    bit                stall;
    bit                hold;
    logic [3:0][15:0]  e8;
    logic [3:0][15:0]  e0;
  } vec_t;

  int npass = 0;
  int ntot = 0;
  int done_cnt = 0;
  bit rand_mode = 1'b0;
  logic [16:0] q8[$];
  logic [16:0] q0[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else npass++;
  endtask

  function automatic vec_t mk(logic [7:0] off, logic [15:0] sc, bit ramp, logic [7:0] pix,
                              bit stall, bit hold, logic [15:0] a0, logic [15:0] a1,
                              logic [15:0] a2, logic [15:0] a3, logic [15:0] b0,
                              logic [15:0] b1, logic [15:0] b2, logic [15:0] b3);
    vec_t v;
    v.off = off; v.scale = sc; v.ramp = ramp; v.pix = pix; v.stall = stall; v.hold = hold;
    v.e8[0] = a0; v.e8[1] = a1; v.e8[2] = a2; v.e8[3] = a3;
    v.e0[0] = b0; v.e0[1] = b1; v.e0[2] = b2; v.e0[3] = b3;
    return v;
  endfunction

  // Output ready: always 1, or a fresh coin flip each cycle when rand_mode is set.
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: capture handshakes, count ap_done, and check stall stability.
  bit          prev_stall = 1'b0;
  logic [16:0] prev_out = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {m8_tvalid, m8_tlast, m8_tdata}, {1'b1, prev_out});
      if (m8_tvalid && !m_axis_tready) chk("stall_sready", 32'(s_axis_tready), 0);
      if (m8_tvalid && m_axis_tready) q8.push_back({m8_tlast, m8_tdata});
      if (m0_tvalid && m_axis_tready) q0.push_back({m0_tlast, m0_tdata});
      if (ap_done) done_cnt++;
      prev_stall = m8_tvalid && !m_axis_tready;
      prev_out   = {m8_tlast, m8_tdata};
    end
  end

  task automatic send_pix(input int idx, input logic [7:0] pix);
    bit hs;
    int waits;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = pix;
    in_row        = 2'(idx / 4);
    in_col        = 2'(idx % 4);
    waits = 0;
    do begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #1;
      waits++;
    end while (!hs && waits < 200);
    if (!hs) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_frame(input vec_t v, input int fi);
    int n;
    logic [16:0] got;
    q8.delete();
    q0.delete();
    done_cnt = 0;
    @(posedge clk);
    #1;
    norm_offset = v.off;
    norm_scale  = v.scale;
    ap_start    = 1'b1;
    @(negedge clk);
    chk($sformatf("f%0d_start_ready", fi), 32'(ap_ready), 1);
    @(posedge clk);
    #1;
    // Scramble config after the handshake; only the latched values may be used.
    norm_offset = 8'hAA;
    norm_scale  = 16'h1234;
    if (!v.hold) ap_start = 1'b0;
    rand_mode = v.stall;
    for (int idx = 0; idx < 16; idx++) send_pix(idx, v.ramp ? 8'(idx) : v.pix);
    s_axis_tvalid = 1'b0;
    ap_start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ap_done && n < 300);
    chk($sformatf("f%0d_done_seen", fi), 32'(ap_done), 1);
    if (!v.stall) chk($sformatf("f%0d_done_latency", fi), n, 2);
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk($sformatf("f%0d_done_pulses", fi), done_cnt, 1);
    chk($sformatf("f%0d_idle_after", fi), {ap_idle, ap_ready}, 2'b11);
    chk($sformatf("f%0d_count8", fi), q8.size(), 4);
    chk($sformatf("f%0d_count0", fi), q0.size(), 4);
    for (int k = 0; k < 4; k++) begin
      got = 'x;
      if (k < q8.size()) got = q8[k];
      chk($sformatf("f%0d_out8_%0d", fi, k), 32'(got), {15'd0, (k == 3), v.e8[k]});
      got = 'x;
      if (k < q0.size()) got = q0[k];
      chk($sformatf("f%0d_out0_%0d", fi, k), 32'(got), {15'd0, (k == 3), v.e0[k]});
    end
  endtask

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(8'd0,   16'd256,  1, 8'd0,   0, 0, 16'd5, 16'd6, 16'd9, 16'd10,
                 16'h0500, 16'h0600, 16'h0900, 16'h0A00);
    vecs[1] = mk(8'd20,  16'd256,  0, 8'd10,  0, 0, 16'hFFF6, 16'hFFF6, 16'hFFF6, 16'hFFF6,
                 16'hF600, 16'hF600, 16'hF600, 16'hF600);
    vecs[2] = mk(8'd0,   16'h7FFF, 0, 8'd255, 0, 0, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F,
                 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    vecs[3] = mk(8'd255, 16'h8000, 0, 8'd0,   0, 0, 16'h7F80, 16'h7F80, 16'h7F80, 16'h7F80,
                 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    vecs[4] = mk(8'd0,   16'h8000, 0, 8'd255, 0, 0, 16'h8080, 16'h8080, 16'h8080, 16'h8080,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    vecs[5] = mk(8'd8,   16'd512,  1, 8'd0,   0, 0, 16'hFFFA, 16'hFFFC, 16'h0002, 16'h0004,
                 16'hFA00, 16'hFC00, 16'h0200, 16'h0400);
    vecs[6] = vecs[0];
    vecs[6].stall = 1'b1;
    vecs[7] = vecs[0];
    vecs[7].hold = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_flags", {ap_idle, ap_ready, ap_done}, 3'b110);
    chk("rst_sready", 32'(s_axis_tready), 0);
    chk("rst_mout", {m8_tvalid, m8_tlast, m8_tdata}, 0);
`ifdef CROP_NORM_STATS_EN
    chk("rst_stats", {stat_min, stat_max, 6'd0, stat_sum}, {8'hFF, 8'h00, 16'h0});
`endif

    // Input valid while idle must not be accepted.
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_sready", 32'(s_axis_tready), 0);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], i);
`ifdef CROP_NORM_STATS_EN
      if (i == 0) chk("stats_t1", {stat_min, stat_max, 6'd0, stat_sum}, {8'd5, 8'd10, 16'd30});
`endif
    end

    // Reset in the middle of a frame after 7 accepted pixels.
    @(posedge clk);
    #1;
    norm_offset = 8'd0;
    norm_scale  = 16'd256;
    ap_start    = 1'b1;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    for (int idx = 0; idx < 7; idx++) send_pix(idx, 8'(idx));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_flags", {ap_idle, ap_ready, ap_done}, 3'b110);
    chk("midrst_mvalid", 32'(m8_tvalid), 0);
    chk("midrst_sready", 32'(s_axis_tready), 0);
    s_axis_tvalid = 1'b0;
    run_frame(vecs[0], 8);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
